mem_word_ctrl: RTL and testbench

- Sequencer between the CPU memory port and the 64K x 8 single-port block RAM.
- Converts one 16-bit word or 8-bit byte request into one or two RAM byte cycles.
- Accounts for the RAM's registered-address read: read data is valid the cycle after the address edge.
- Provides a valid/ready request side and a single-cycle response pulse to the CPU.

---
 rtl/mem_word_ctrl_if.sv | 23 ++
 rtl/mem_word_ctrl.sv | 63 ++++++
 tb/tb_mem_word_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_word_ctrl_if.sv
// mem_word_ctrl_if: CPU request/response and RAM byte-port signals of the word controller
interface mem_word_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic        req_byte;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        resp_valid;
   logic [15:0] resp_rdata;
   logic [15:0] ram_addr;
   logic [7:0]  ram_data;
   logic        ram_we;
   logic [7:0]  ram_q;
   modport slave (
      input  req_valid, req_we, req_byte, req_addr, req_wdata, ram_q,
      output req_ready, resp_valid, resp_rdata, ram_addr, ram_data, ram_we
   );
   modport master (
      output req_valid, req_we, req_byte, req_addr, req_wdata, ram_q,
      input  req_ready, resp_valid, resp_rdata, ram_addr, ram_data, ram_we
   );
endinterface

// File: rtl/mem_word_ctrl.sv
// mem_word_ctrl: splits 16-bit word / 8-bit byte CPU requests into byte cycles on a registered-read RAM
module mem_word_ctrl #(
   parameter bit BIG_ENDIAN = 1'b0
) (
   input logic clk,
   input logic rst,
   mem_word_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, WR0, WR1, DONE} state_t;
   state_t state, nxt;
   logic        byte_m;
   logic [15:0] addr, addr1, wdata, last_addr, rdata;
   logic [7:0]  last_data, b0, first_b, second_b;
   assign addr1    = addr + 16'd1;
   assign first_b  = (byte_m || !BIG_ENDIAN) ? wdata[7:0] : wdata[15:8];
   assign second_b = BIG_ENDIAN ? wdata[7:0] : wdata[15:8];
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = bus.req_valid ? (bus.req_we ? WR0 : RD0) : IDLE;
         RD0:     nxt = RD1;
         RD1:     nxt = byte_m ? DONE : RD2;
         RD2:     nxt = DONE;
         WR0:     nxt = byte_m ? DONE : WR1;
         WR1:     nxt = DONE;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end
   assign bus.req_ready  = state == IDLE;
   assign bus.resp_valid = state == DONE;
   assign bus.resp_rdata = rdata;
   // gated by rst so an aborted write never lands its pending byte
   assign bus.ram_we     = (state == WR0 || state == WR1) && !rst;
   assign bus.ram_addr   = (state == RD0 || state == WR0) ? addr :
                           (state == RD1 || state == WR1) ? addr1 : last_addr;
   assign bus.ram_data   = state == WR0 ? first_b : state == WR1 ? second_b : last_data;
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_m    <= 1'b0;
         addr      <= 16'h0000;
         wdata     <= 16'h0000;
         last_addr <= 16'h0000;
         last_data <= 8'h00;
         rdata     <= 16'h0000;
         b0        <= 8'h00;
      end else begin
         last_addr <= bus.ram_addr;
         last_data <= bus.ram_data;
         if (state == IDLE && bus.req_valid) begin
            byte_m <= bus.req_byte;
            addr   <= bus.req_addr;
            wdata  <= bus.req_wdata;
         end
         if (state == RD1 && byte_m) rdata <= {8'h00, bus.ram_q};
         if (state == RD1 && !byte_m) b0 <= bus.ram_q;
         if (state == RD2) rdata <= BIG_ENDIAN ? {b0, bus.ram_q} : {bus.ram_q, b0};
      end
   end
endmodule

// File: tb/tb_mem_word_ctrl.sv
// tb_mem_word_ctrl: directed checks of little- and big-endian controllers running in lockstep on private RAM models
module tb_mem_word_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;
   mem_word_ctrl_if b0 ();
   mem_word_ctrl_if b1 ();
   mem_word_ctrl #(.BIG_ENDIAN(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
   mem_word_ctrl #(.BIG_ENDIAN(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
   always #5 clk = ~clk;
   assign b1.req_valid = b0.req_valid;
   assign b1.req_we    = b0.req_we;
   assign b1.req_byte  = b0.req_byte;
   assign b1.req_addr  = b0.req_addr;
   assign b1.req_wdata = b0.req_wdata;
   logic [7:0]  mem0 [0:65535];
   logic [7:0]  mem1 [0:65535];
   logic [7:0]  q0, q1, bd_data;
   logic [15:0] bd_addr;
   logic        bd_we = 1'b0;
   assign b0.ram_q = q0;
   assign b1.ram_q = q1;
   always @(posedge clk) begin
      if (bd_we) begin
         mem0[bd_addr] <= bd_data;
         mem1[bd_addr] <= bd_data;
      end else begin
         if (b0.ram_we) mem0[b0.ram_addr] <= b0.ram_data;
         if (b1.ram_we) mem1[b1.ram_addr] <= b1.ram_data;
      end
      q0 <= mem0[b0.ram_addr];
      q1 <= mem1[b1.ram_addr];
   end
   int          lat, wes;
   logic [15:0] rd0, rd1;
   task automatic bd(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(negedge clk);
      bd_we = 1'b0;
   endtask
   task automatic do_op(input logic we, input logic bt, input logic [15:0] a, input logic [15:0] wd);
      @(negedge clk);
      b0.req_valid = 1'b1; b0.req_we = we; b0.req_byte = bt; b0.req_addr = a; b0.req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      b0.req_valid = 1'b0; b0.req_addr = ~a; b0.req_wdata = ~wd; b0.req_we = ~we; b0.req_byte = ~bt;
      lat = -1; wes = 0; rd0 = 16'hxxxx; rd1 = 16'hxxxx;
      for (int n = 0; n < 20; n++) begin
         if (b0.ram_we) wes++;
         if (b0.resp_valid) begin
            lat = n; rd0 = b0.resp_rdata; rd1 = b1.resp_rdata;
            break;
         end
         @(negedge clk);
      end
   endtask
   task automatic test_reset;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      checks += 6;
      if (b0.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b exp 1", b0.req_ready); end
      if (b0.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp got %b exp 0", b0.resp_valid); end
      if (b0.resp_rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got %h exp 0000", b0.resp_rdata); end
      if (b0.ram_we !== 1'b0) begin failures++; $display("FAIL reset_we got %b exp 0", b0.ram_we); end
      if (b0.ram_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr got %h exp 0000", b0.ram_addr); end
      if (b0.ram_data !== 8'h00) begin failures++; $display("FAIL reset_data got %h exp 00", b0.ram_data); end
   endtask
   task automatic test_word_write;
      do_op(1'b1, 1'b0, 16'h1000, 16'hBEEF);
      checks += 6;
      if (lat !== 2) begin failures++; $display("FAIL ww_latency got %0d exp 2", lat); end
      if (wes !== 2) begin failures++; $display("FAIL ww_we_cycles got %0d exp 2", wes); end
      if (mem0[16'h1000] !== 8'hEF) begin failures++; $display("FAIL ww_lo got %h exp EF", mem0[16'h1000]); end
      if (mem0[16'h1001] !== 8'hBE) begin failures++; $display("FAIL ww_hi got %h exp BE", mem0[16'h1001]); end
      if (mem1[16'h1000] !== 8'hBE) begin failures++; $display("FAIL ww_be_a got %h exp BE", mem1[16'h1000]); end
      if (mem1[16'h1001] !== 8'hEF) begin failures++; $display("FAIL ww_be_a1 got %h exp EF", mem1[16'h1001]); end
   endtask
   task automatic test_reads;
      do_op(1'b0, 1'b0, 16'h1000, 16'h0000);
      checks += 3;
      if (lat !== 3) begin failures++; $display("FAIL wr_latency got %0d exp 3", lat); end
      if (rd0 !== 16'hBEEF) begin failures++; $display("FAIL wr_data got %h exp BEEF", rd0); end
      if (rd1 !== 16'hBEEF) begin failures++; $display("FAIL wr_be_data got %h exp BEEF", rd1); end
      do_op(1'b0, 1'b1, 16'h1001, 16'h0000);
      checks += 2;
      if (lat !== 2) begin failures++; $display("FAIL br_latency got %0d exp 2", lat); end
      if (rd0 !== 16'h00BE) begin failures++; $display("FAIL br_data got %h exp 00BE", rd0); end
   endtask
   task automatic test_byte_write;
      do_op(1'b1, 1'b1, 16'h1002, 16'h77CC);
      checks += 6;
      if (lat !== 1) begin failures++; $display("FAIL bw_latency got %0d exp 1", lat); end
      if (wes !== 1) begin failures++; $display("FAIL bw_we_cycles got %0d exp 1", wes); end
      if (mem0[16'h1002] !== 8'hCC) begin failures++; $display("FAIL bw_byte got %h exp CC", mem0[16'h1002]); end
      if (mem0[16'h1003] !== 8'h5D) begin failures++; $display("FAIL bw_next got %h exp 5D", mem0[16'h1003]); end
      if (mem1[16'h1002] !== 8'hCC) begin failures++; $display("FAIL bw_be_byte got %h exp CC", mem1[16'h1002]); end
      if (rd0 !== 16'h00BE) begin failures++; $display("FAIL bw_rdata_hold got %h exp 00BE", rd0); end
   endtask
   task automatic test_wrap;
      do_op(1'b1, 1'b0, 16'hFFFF, 16'h1234);
      checks += 2;
      if (mem0[16'hFFFF] !== 8'h34) begin failures++; $display("FAIL wrap_ffff got %h exp 34", mem0[16'hFFFF]); end
      if (mem0[16'h0000] !== 8'h12) begin failures++; $display("FAIL wrap_0000 got %h exp 12", mem0[16'h0000]); end
      do_op(1'b0, 1'b0, 16'hFFFF, 16'h0000);
      checks += 2;
      if (rd0 !== 16'h1234) begin failures++; $display("FAIL wrap_read got %h exp 1234", rd0); end
      if (rd1 !== 16'h1234) begin failures++; $display("FAIL wrap_be_read got %h exp 1234", rd1); end
   endtask
   task automatic test_big_endian;
      do_op(1'b1, 1'b0, 16'h0200, 16'hA55A);
      checks += 3;
      if (mem1[16'h0200] !== 8'hA5) begin failures++; $display("FAIL be_a got %h exp A5", mem1[16'h0200]); end
      if (mem1[16'h0201] !== 8'h5A) begin failures++; $display("FAIL be_a1 got %h exp 5A", mem1[16'h0201]); end
      if (mem0[16'h0200] !== 8'h5A) begin failures++; $display("FAIL le_a got %h exp 5A", mem0[16'h0200]); end
      do_op(1'b0, 1'b0, 16'h0200, 16'h0000);
      checks += 2;
      if (rd1 !== 16'hA55A) begin failures++; $display("FAIL be_read got %h exp A55A", rd1); end
      if (rd0 !== 16'hA55A) begin failures++; $display("FAIL le_read got %h exp A55A", rd0); end
   endtask
   task automatic test_back_to_back;
      logic [15:0] exp_d [0:2];
      int acc, rsp;
      exp_d[0] = 16'h0100; exp_d[1] = 16'h5150; exp_d[2] = 16'hA1A0;
      acc = 0; rsp = 0;
      @(negedge clk);
      b0.req_valid = 1'b1; b0.req_we = 1'b0; b0.req_byte = 1'b0;
      for (int i = 0; i < 15; i++) begin
         b0.req_addr = 16'h2000 + 16'(i * 16);
         #1;
         if (b0.req_ready) acc++;
         if (b0.resp_valid) begin
            checks++;
            if (rsp < 3 && b0.resp_rdata !== exp_d[rsp]) begin
               failures++; $display("FAIL b2b_data%0d got %h exp %h", rsp, b0.resp_rdata, exp_d[rsp]);
            end
            rsp++;
         end
         @(negedge clk);
      end
      b0.req_valid = 1'b0;
      checks += 2;
      if (acc !== 3) begin failures++; $display("FAIL b2b_accepts got %0d exp 3", acc); end
      if (rsp !== 3) begin failures++; $display("FAIL b2b_responses got %0d exp 3", rsp); end
   endtask
   task automatic test_reset_mid;
      int rsp;
      rsp = 0;
      @(negedge clk);
      b0.req_valid = 1'b1; b0.req_we = 1'b1; b0.req_byte = 1'b0; b0.req_addr = 16'h3000; b0.req_wdata = 16'hCAFE;
      @(posedge clk);
      @(negedge clk);
      b0.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (b0.ram_we !== 1'b0) begin failures++; $display("FAIL rstmid_we_gate got %b exp 0", b0.ram_we); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks += 8;
      if (b0.req_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got %b exp 1", b0.req_ready); end
      if (b0.resp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_resp got %b exp 0", b0.resp_valid); end
      if (b0.resp_rdata !== 16'h0000) begin failures++; $display("FAIL rstmid_rdata got %h exp 0000", b0.resp_rdata); end
      if (b0.ram_we !== 1'b0) begin failures++; $display("FAIL rstmid_ram_we got %b exp 0", b0.ram_we); end
      if (b0.ram_addr !== 16'h0000) begin failures++; $display("FAIL rstmid_addr got %h exp 0000", b0.ram_addr); end
      if (b0.ram_data !== 8'h00) begin failures++; $display("FAIL rstmid_data got %h exp 00", b0.ram_data); end
      if (mem0[16'h3000] !== 8'hFE) begin failures++; $display("FAIL rstmid_first got %h exp FE", mem0[16'h3000]); end
      if (mem0[16'h3001] !== 8'h00) begin failures++; $display("FAIL rstmid_second got %h exp 00", mem0[16'h3001]); end
      for (int i = 0; i < 4; i++) begin
         if (b0.resp_valid) rsp++;
         @(negedge clk);
      end
      checks++;
      if (rsp !== 0) begin failures++; $display("FAIL rstmid_no_resp got %0d exp 0", rsp); end
   endtask
   initial begin
      b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_byte = 1'b0; b0.req_addr = 16'h0; b0.req_wdata = 16'h0;
      bd_addr = 16'h0; bd_data = 8'h0;
      bd(16'h1003, 8'h5D);
      bd(16'h3000, 8'h00);
      bd(16'h3001, 8'h00);
      for (int i = 0; i < 256; i++) bd(16'h2000 + 16'(i), 8'(i));
      test_reset;
      test_word_write;
      test_reads;
      test_byte_write;
      test_wrap;
      test_big_endian;
      test_back_to_back;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
